// File: rtl/fm_pkg.sv
// Shared FM synthesis types: field widths, the channel attribute RAM word, and the
// channel-sequencer FSM states.
package fm_pkg;

    localparam int FM_CH_W      = 5;
    localparam int FM_FNUM_W    = 10;
    localparam int FM_BLOCK_W   = 3;
    localparam int FM_PINC_W    = 17;
    localparam int FM_FB_W      = 3;
    localparam int FM_NUM_CH_MAX = 1 << FM_CH_W;

    // Field order matches the 20-bit attribute RAM word, MSB first.
    typedef struct packed {
        logic                  chb;
        logic                  cha;
        logic [FM_FB_W-1:0]    fb;
        logic                  alg;
        logic                  kon;
        logic [FM_BLOCK_W-1:0] block;
        logic [FM_FNUM_W-1:0]  fnum;
    } fm_ch_attr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_CAP  = 2'd2,
        ST_HOLD = 2'd3
    } fm_seq_state_t;

endpackage

// File: rtl/fm_ch_seq_if.sv
// Per-channel record stream from the channel sequencer to the operator pipeline
// (valid/ready handshake).
interface fm_ch_seq_if;
    import fm_pkg::*;

    logic                  out_valid;
    logic                  out_ready;
    logic [FM_CH_W-1:0]    out_ch;
    logic                  out_chb;
    logic                  out_cha;
    logic [FM_FB_W-1:0]    out_fb;
    logic                  out_alg;
    logic                  out_kon;
    logic [FM_PINC_W-1:0]  out_phase_inc;
    logic                  out_key_on;
    logic                  out_key_off;

    modport master (
        output out_valid, out_ch, out_chb, out_cha, out_fb, out_alg, out_kon,
               out_phase_inc, out_key_on, out_key_off,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_ch, out_chb, out_cha, out_fb, out_alg, out_kon,
               out_phase_inc, out_key_on, out_key_off,
        output out_ready
    );

endinterface

// File: rtl/fm_phase_inc.sv
// Phase increment from frequency number and octave block: fnum shifted left by block,
// exact in 17 bits (max 1023 << 7 = 130944).
module fm_phase_inc
    import fm_pkg::*;
(
    input  logic [FM_FNUM_W-1:0]  fnum,
    input  logic [FM_BLOCK_W-1:0] block,
    output logic [FM_PINC_W-1:0]  phase_inc
);

    assign phase_inc = {{(FM_PINC_W - FM_FNUM_W){1'b0}}, fnum} << block;

endmodule

// File: rtl/fm_ch_seq.sv
// FM channel sequencer: on each sample tick, reads channels 0..NUM_CH-1 from the attribute
// RAM and emits one record per channel. Key edge detection only with FM_CH_SEQ_KEYEVT_EN.
module fm_ch_seq
    import fm_pkg::*;
#(
    parameter int NUM_CH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_tick,
    output logic [FM_CH_W-1:0]    ch_sel,
    input  logic                  ch_chb,
    input  logic                  ch_cha,
    input  logic [FM_FB_W-1:0]    ch_fb,
    input  logic                  ch_alg,
    input  logic                  ch_kon,
    input  logic [FM_BLOCK_W-1:0] ch_block,
    input  logic [FM_FNUM_W-1:0]  ch_fnum,
    fm_ch_seq_if.master           rec,
    output logic                  busy,
    output logic                  scan_done,
    output logic                  overrun
);

    if (NUM_CH < 1 || NUM_CH > FM_NUM_CH_MAX) begin : g_bad_num_ch
        $error("fm_ch_seq: NUM_CH out of range 1..32");
    end

    localparam logic [FM_CH_W-1:0] LAST_IDX = FM_CH_W'(NUM_CH - 1);

    fm_seq_state_t        state, state_nx;
    logic [FM_CH_W-1:0]   idx;
    fm_ch_attr_t          attr;
    logic [FM_PINC_W-1:0] pinc;
    logic                 start;
    logic                 cap;
    logic                 accept;
    logic                 last;

    assign attr   = {ch_chb, ch_cha, ch_fb, ch_alg, ch_kon, ch_block, ch_fnum};
    assign ch_sel = idx;
    assign last   = (idx == LAST_IDX);

    fm_phase_inc u_phase_inc (
        .fnum      (attr.fnum),
        .block     (attr.block),
        .phase_inc (pinc)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nx = state;
        start    = 1'b0;
        cap      = 1'b0;
        accept   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (sample_tick) begin
                    start    = 1'b1;
                    state_nx = ST_SEL;
                end
            end
            ST_SEL: begin
                state_nx = ST_CAP;
            end
            ST_CAP: begin
                cap      = 1'b1;
                state_nx = ST_HOLD;
            end
            ST_HOLD: begin
                if (rec.out_valid && rec.out_ready) begin
                    accept   = 1'b1;
                    state_nx = last ? ST_IDLE : ST_SEL;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Scan control: channel index, busy/done status and the sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            busy      <= 1'b0;
            scan_done <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            scan_done <= accept && last;
            if (start) begin
                idx  <= '0;
                busy <= 1'b1;
            end else if (accept) begin
                if (last) begin
                    busy <= 1'b0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            if (sample_tick && busy) begin
                overrun <= 1'b1;
            end
        end
    end

    // Record register: loaded in CAP, held until the handshake completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec.out_valid     <= 1'b0;
            rec.out_ch        <= '0;
            rec.out_chb       <= 1'b0;
            rec.out_cha       <= 1'b0;
            rec.out_fb        <= '0;
            rec.out_alg       <= 1'b0;
            rec.out_kon       <= 1'b0;
            rec.out_phase_inc <= '0;
        end else begin
            if (cap) begin
                rec.out_valid     <= 1'b1;
                rec.out_ch        <= idx;
                rec.out_chb       <= attr.chb;
                rec.out_cha       <= attr.cha;
                rec.out_fb        <= attr.fb;
                rec.out_alg       <= attr.alg;
                rec.out_kon       <= attr.kon;
                rec.out_phase_inc <= pinc;
            end else if (accept) begin
                rec.out_valid <= 1'b0;
            end
        end
    end

`ifdef FM_CH_SEQ_KEYEVT_EN
    logic [NUM_CH-1:0] kon_hist;

    // History commits only on an accepted record, so a stalled record never loses an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the history is reset because a fresh scan after reset must report held keys as new key-ons.
            kon_hist        <= '0;
            rec.out_key_on  <= 1'b0;
            rec.out_key_off <= 1'b0;
        end else begin
            if (cap) begin
                rec.out_key_on  <= attr.kon & ~kon_hist[idx];
                rec.out_key_off <= ~attr.kon & kon_hist[idx];
            end
            if (accept) begin
                kon_hist[idx] <= rec.out_kon;
            end
        end
    end
`else
    assign rec.out_key_on  = 1'b0;
    assign rec.out_key_off = 1'b0;
`endif

endmodule

// File: tb/tb_fm_ch_seq.sv
// Bench for fm_ch_seq: a behavioural attribute RAM, a scoreboard of expected records
// filled at each tick, a table of phase-increment corner vectors, and multi-cycle sequences.
module tb_fm_ch_seq;
    import fm_pkg::*;

    localparam int NUM_CH = 32;
`ifdef FM_CH_SEQ_KEYEVT_EN
    localparam bit KEYEVT = 1'b1;
`else
    localparam bit KEYEVT = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  sample_tick = 1'b0;
    logic [FM_CH_W-1:0]    ch_sel;
    logic                  ch_chb, ch_cha, ch_alg, ch_kon;
    logic [FM_FB_W-1:0]    ch_fb;
    logic [FM_BLOCK_W-1:0] ch_block;
    logic [FM_FNUM_W-1:0]  ch_fnum;
    logic                  busy, scan_done, overrun;

    fm_ch_seq_if bus ();

    fm_ch_seq #(.NUM_CH(NUM_CH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .ch_sel      (ch_sel),
        .ch_chb      (ch_chb),
        .ch_cha      (ch_cha),
        .ch_fb       (ch_fb),
        .ch_alg      (ch_alg),
        .ch_kon      (ch_kon),
        .ch_block    (ch_block),
        .ch_fnum     (ch_fnum),
        .rec         (bus),
        .busy        (busy),
        .scan_done   (scan_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    fm_ch_attr_t ram [NUM_CH];
    assign {ch_chb, ch_cha, ch_fb, ch_alg, ch_kon, ch_block, ch_fnum} = ram[ch_sel];

    typedef struct {
        logic [FM_CH_W-1:0]   ch;
        fm_ch_attr_t          a;
        logic [FM_PINC_W-1:0] pinc;
    } exp_t;

    typedef struct {
        logic [FM_FNUM_W-1:0]  fnum;
        logic [FM_BLOCK_W-1:0] block;
        logic [FM_PINC_W-1:0]  exp_pinc;
    } vec_t;

    exp_t                 sb [$];
    int                   n_vec = 0;
    int                   n_err = 0;
    int                   cyc = 0;
    int                   t_tick = 0;
    int                   first_cyc = 0;
    int                   done_cyc = 0;
    int                   hs_cnt = 0;
    int                   stall_cnt = 0;
    bit                   first_seen = 1'b0;
    bit                   done_seen = 1'b0;
    bit                   rand_ready = 1'b0;
    bit                   stall7 = 1'b0;
    bit                   prev_stall = 1'b0;
    logic [28:0]          prev_rec = '0;
    logic [NUM_CH-1:0]    model_hist = '0;
    logic [FM_PINC_W-1:0] got_pinc [NUM_CH];
    logic                 got3_on = 1'b0;
    logic                 got3_off = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [FM_PINC_W-1:0] ref_pinc(input int fnum, input int blk);
        return FM_PINC_W'(fnum * (2 ** blk));
    endfunction

    function automatic logic [28:0] dut_rec();
        return {bus.out_ch, bus.out_chb, bus.out_cha, bus.out_fb, bus.out_alg, bus.out_kon,
                bus.out_phase_inc};
    endfunction

    // Ready driver: fixed high, random backpressure, or a hard stall on channel 7.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall7 && bus.out_valid && bus.out_ch == 5'd7) bus.out_ready = 1'b0;
            else if (rand_ready) bus.out_ready = ($urandom_range(0, 99) >= 40);
            else bus.out_ready = 1'b1;
        end
    end

    // Monitor: samples on the falling edge, pops the scoreboard for each handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold", {bus.out_valid, dut_rec()}, {1'b1, prev_rec});
            end
            if (bus.out_valid && !first_seen) begin
                first_seen = 1'b1;
                first_cyc  = cyc;
            end
            if (scan_done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
            if (bus.out_valid && bus.out_ready) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    exp_t e;
                    logic eon, eoff;
                    e = sb.pop_front();
                    check("record", dut_rec(),
                          {e.ch, e.a.chb, e.a.cha, e.a.fb, e.a.alg, e.a.kon, e.pinc});
                    eon  = KEYEVT & e.a.kon & ~model_hist[e.ch];
                    eoff = KEYEVT & ~e.a.kon & model_hist[e.ch];
                    check("key_evt", {bus.out_key_on, bus.out_key_off}, {eon, eoff});
                    model_hist[e.ch] = e.a.kon;
                end
                got_pinc[bus.out_ch] = bus.out_phase_inc;
                if (bus.out_ch == 5'd3) begin
                    got3_on  = bus.out_key_on;
                    got3_off = bus.out_key_off;
                end
            end
            if (bus.out_valid && !bus.out_ready) stall_cnt++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_rec   = dut_rec();
        end
    end

    task automatic do_tick(input bit start);
        @(negedge clk);
        if (start) begin
            for (int n = 0; n < NUM_CH; n++) begin
                sb.push_back('{ch: 5'(n), a: ram[n], pinc: ref_pinc(int'(ram[n].fnum), int'(ram[n].block))});
            end
            first_seen = 1'b0;
            done_seen  = 1'b0;
            hs_cnt     = 0;
        end
        t_tick      = cyc;
        sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
    endtask

    task automatic wait_scan(input string name);
        for (int i = 0; i < 1000 && !done_seen; i++) @(posedge clk);
        check({name, "_done_timeout"}, 64'(done_seen), 64'd1);
        check({name, "_handshakes"}, 64'(hs_cnt), 64'd32);
        check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [8];
        logic [1:0] key_exp_on  [4];
        logic [1:0] key_exp_off [4];
        logic       key_seq     [4];

        vecs[0] = '{fnum: 10'd0,    block: 3'd0, exp_pinc: 17'd0};
        vecs[1] = '{fnum: 10'd1,    block: 3'd0, exp_pinc: 17'd1};
        vecs[2] = '{fnum: 10'd1,    block: 3'd7, exp_pinc: 17'd128};
        vecs[3] = '{fnum: 10'd1023, block: 3'd0, exp_pinc: 17'd1023};
        vecs[4] = '{fnum: 10'd512,  block: 3'd7, exp_pinc: 17'd65536};
        vecs[5] = '{fnum: 10'd1023, block: 3'd7, exp_pinc: 17'd130944};
        vecs[6] = '{fnum: 10'd0,    block: 3'd5, exp_pinc: 17'd0};
        vecs[7] = '{fnum: 10'd5,    block: 3'd3, exp_pinc: 17'd40};
        key_seq = '{1'b0, 1'b1, 1'b1, 1'b0};
        key_exp_on  = '{2'd0, 2'(KEYEVT), 2'd0, 2'd0};
        key_exp_off = '{2'd0, 2'd0, 2'd0, 2'(KEYEVT)};

        for (int n = 0; n < NUM_CH; n++) begin
            ram[n] = '{chb: n[0], cha: n[1], fb: 3'(n * 3), alg: n[2], kon: 1'b0,
                       block: 3'(n % 8), fnum: 10'(n * 31)};
            got_pinc[n] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(scan_done), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_ch_sel", 64'(ch_sel), 64'd0);
        check("rst_rec", 64'(dut_rec()), 64'd0);
        check("rst_keys", {bus.out_key_on, bus.out_key_off}, 64'd0);
        rst_n = 1'b1;

        // Full scan, ready always high: latency and throughput
        do_tick(1'b1);
        wait_scan("scan1");
        check("first_valid_latency", 64'(first_cyc - t_tick), 64'd3);
        check("scan_done_latency", 64'(done_cyc - t_tick), 64'd97);
        check("busy_after_scan", 64'(busy), 64'd0);
        for (int n = 0; n < NUM_CH; n++) begin
            check("scan1_pinc", 64'(got_pinc[n]), 64'(n * 31) << (n % 8));
        end

        // Phase-increment corner table under random backpressure
        for (int i = 0; i < 8; i++) begin
            ram[i].fnum  = vecs[i].fnum;
            ram[i].block = vecs[i].block;
        end
        rand_ready = 1'b1;
        stall_cnt  = 0;
        do_tick(1'b1);
        wait_scan("bp_scan");
        for (int i = 0; i < 8; i++) begin
            check("vec_pinc", 64'(got_pinc[i]), 64'(vecs[i].exp_pinc));
        end
        check("bp_stalls_seen", 64'(stall_cnt > 0), 64'd1);

        // Key-on/off edge sequence on channel 3
        for (int i = 0; i < 4; i++) begin
            ram[3].kon = key_seq[i];
            do_tick(1'b1);
            wait_scan("key_scan");
            check("ch3_key_on", 64'(got3_on), 64'(key_exp_on[i]));
            check("ch3_key_off", 64'(got3_off), 64'(key_exp_off[i]));
        end
        rand_ready = 1'b0;

        // Tick arriving mid-scan sets the sticky overrun and starts nothing
        check("overrun_before", 64'(overrun), 64'd0);
        do_tick(1'b1);
        for (int i = 0; i < 200 && hs_cnt < 10; i++) @(negedge clk);
        check("reach_record10", 64'(hs_cnt >= 10), 64'd1);
        do_tick(1'b0);
        wait_scan("overrun_scan");
        check("overrun_set", 64'(overrun), 64'd1);
        repeat (10) @(negedge clk);
        check("no_second_scan", {busy, bus.out_valid}, 64'd0);
        check("overrun_sticky", 64'(overrun), 64'd1);

        // Reset during HOLD of channel 7 aborts and clears key history
        ram[3].kon = 1'b1;
        do_tick(1'b1);
        wait_scan("kon_scan");
        check("held_key_on_first", 64'(got3_on), 64'(KEYEVT));
        do_tick(1'b1);
        wait_scan("kon_scan2");
        check("held_key_on_again", 64'(got3_on), 64'd0);
        stall7 = 1'b1;
        do_tick(1'b1);
        for (int i = 0; i < 200 && !(bus.out_valid && bus.out_ch == 5'd7); i++) @(negedge clk);
        check("reach_ch7_hold", {bus.out_valid, bus.out_ch}, {1'b1, 5'd7});
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", 64'(bus.out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_overrun", 64'(overrun), 64'd0);
        check("abort_ch_sel", 64'(ch_sel), 64'd0);
        sb.delete();
        model_hist = '0;
        stall7     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_tick(1'b1);
        wait_scan("post_reset_scan");
        check("post_reset_key_on", 64'(got3_on), 64'(KEYEVT));
        check("post_reset_first_ch", 64'(got_pinc[0]), 64'(vecs[0].exp_pinc));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
